display_scan_ctrl: RTL

- Time-multiplexing scheduler for the 4-digit common-anode seven-segment display.
- Shares the single `segmentDisplay` decoder between four digit positions. Each refresh slot it drives the active-low anode select `enable` and the 4-bit digit code `digit` to the decoder.
- Selects between the operand value and the answer value. Latches the selected value into a shadow buffer only at frame boundaries, so the display never tears mid-scan.
- Applies leading-zero blanking and a minus sign.

---
 rtl/disp_pkg.sv | 21 ++
 rtl/disp_frame_fmt.sv | 59 +++++
 rtl/display_scan_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Optional build macro used by display_scan_ctrl: DISP_DEADTIME_EN.
package disp_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t     DIG_MINUS  = 4'd10;
  localparam digit_t     DIG_BLANK  = 4'd11;
  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;

  // Any code outside 0..9 is shown as a blank digit.
  function automatic digit_t bcd_sanitize(input logic [3:0] code);
    return (code > 4'd9) ? DIG_BLANK : code;
  endfunction

  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/disp_frame_fmt.sv
// Builds one display frame: source select, BCD sanitise, leading-zero
// blanking and placement of the minus sign next to the leading digit.
module disp_frame_fmt
  import disp_pkg::*;
(
  input  logic                        show_ans_i,
  input  logic                        blank_lz_i,
  input  logic                        ans_neg_i,
  input  logic [15:0]                 opnd_i,
  input  logic [11:0]                 ans_i,
  output digit_t [NUM_DIGITS-1:0]     frame_o
);

  digit_t [NUM_DIGITS-1:0] raw;
  logic   [NUM_DIGITS-1:0] lz_mask;
  logic                    lead;
  logic                    use_minus;
  logic   [1:0]            minus_pos;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latches are inferred.
    raw       = '0;
    lz_mask   = '0;
    lead      = 1'b1;
    minus_pos = 2'd3;
    use_minus = show_ans_i && ans_neg_i;

    if (show_ans_i) begin
      for (int i = 0; i < 3; i++) begin
        raw[i] = bcd_sanitize(ans_i[4*i +: 4]);
      end
      raw[3] = (use_minus && !blank_lz_i) ? DIG_MINUS : 4'd0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        raw[i] = bcd_sanitize(opnd_i[4*i +: 4]);
      end
    end

    frame_o = raw;

    // The blanked run is contiguous from the top; its lowest position is
    // where a minus sign belongs.
    if (blank_lz_i) begin
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (lead && raw[i] == 4'd0) begin
          frame_o[i] = DIG_BLANK;
          lz_mask[i] = 1'b1;
        end else begin
          lead = 1'b0;
        end
      end
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (lz_mask[i]) minus_pos = 2'(i);
      end
      if (use_minus) frame_o[minus_pos] = DIG_MINUS;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with tear-free frame shadowing.
// Build macro DISP_DEADTIME_EN: blank all anodes for DEAD_CYCLES at each slot start.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] opnd,
  input  logic [11:0] ans,
  input  logic        ans_neg,
  input  logic        showAns,
  input  logic        blank_lz,
  output logic [3:0]  enable,
  output logic [3:0]  digit,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  if (REFRESH_DIV < 2 || REFRESH_DIV > (1 << 20)) begin : g_bad_div
    $error("display_scan_ctrl: REFRESH_DIV out of range 2..2^20");
  end
  if (DEAD_CYCLES < 0 || DEAD_CYCLES >= REFRESH_DIV) begin : g_bad_dead
    $error("display_scan_ctrl: DEAD_CYCLES must be below REFRESH_DIV");
  end

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              idx_q, idx_d;
  digit_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [3:0]              enable_q, enable_d;
  digit_t                  digit_q, digit_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    tick;
  logic                    frame_load;
  digit_t [NUM_DIGITS-1:0] frame_next;

  disp_frame_fmt u_frame_fmt (
    .show_ans_i (showAns),
    .blank_lz_i (blank_lz),
    .ans_neg_i  (ans_neg),
    .opnd_i     (opnd),
    .ans_i      (ans),
    .frame_o    (frame_next)
  );

`ifdef DISP_DEADTIME_EN
  localparam bit HAS_DEAD = (DEAD_CYCLES > 0);

  // Anode for the current slot, applied once the dead period has elapsed.
  logic [3:0] slot_anode_q, slot_anode_d;
`endif

  always_comb begin
    tick         = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    frame_load   = tick && (idx_q == 2'd3);
    shadow_d     = frame_load ? frame_next : shadow_q;
    digit_d      = tick ? shadow_d[idx_d] : digit_q;
    frame_tick_d = frame_load;
`ifdef DISP_DEADTIME_EN
    slot_anode_d = tick ? anode_sel(idx_d) : slot_anode_q;
    if (tick) begin
      enable_d = HAS_DEAD ? ANODE_OFF : anode_sel(idx_d);
    end else if (HAS_DEAD && cnt_q == CNT_W'(DEAD_CYCLES - 1)) begin
      enable_d = slot_anode_q;
    end else begin
      enable_d = enable_q;
    end
`else
    enable_d     = tick ? anode_sel(idx_d) : enable_q;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; the shadow
  // buffer is reset too, so slots shown before the first frame load are blank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= {NUM_DIGITS{DIG_BLANK}};
      enable_q     <= ANODE_OFF;
      digit_q      <= DIG_BLANK;
      frame_tick_q <= 1'b0;
`ifdef DISP_DEADTIME_EN
      slot_anode_q <= ANODE_OFF;
`endif
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      enable_q     <= enable_d;
      digit_q      <= digit_d;
      frame_tick_q <= frame_tick_d;
`ifdef DISP_DEADTIME_EN
      slot_anode_q <= slot_anode_d;
`endif
    end
  end

  assign enable     = enable_q;
  assign digit      = digit_q;
  assign frame_tick = frame_tick_q;

endmodule
